// File: rtl/data_cache_controller_if.sv
// Bus bundle between the CPU memory stage, the data cache and main data memory.
// The cache is the slave: it answers CPU requests and drives the block port towards memory.
// The master side is the CPU plus the memory model.
interface data_cache_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    // CPU request/response side
    logic                  cpu_read;
    logic                  cpu_write;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [31:0]           cpu_writedata;
    logic [3:0]            cpu_byteen;
    logic [31:0]           cpu_readdata;
    logic                  cpu_busywait;

    // Main-memory block side
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-5:0] mem_address;
    logic [127:0]          mem_writedata;
    logic [127:0]          mem_readdata;
    logic                  mem_busywait;

    modport slave (
        input  cpu_read,
        input  cpu_write,
        input  cpu_address,
        input  cpu_writedata,
        input  cpu_byteen,
        output cpu_readdata,
        output cpu_busywait,
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_writedata,
        input  mem_readdata,
        input  mem_busywait
    );

    modport master (
        output cpu_read,
        output cpu_write,
        output cpu_address,
        output cpu_writedata,
        output cpu_byteen,
        input  cpu_readdata,
        input  cpu_busywait,
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_writedata,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are served combinationally in IDLE; misses stall the CPU while the victim line is
// written back (if dirty) and the requested line is fetched and installed.
module data_cache_controller #(
    parameter int unsigned NUM_SETS   = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    data_cache_controller_if.slave bus
);
    localparam int unsigned INDEX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W   = ADDR_WIDTH - INDEX_W - 4;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StFetch,
        StRefill
    } state_t;

    state_t state_q;

    // Line storage; only valid/dirty are reset, the arrays keep stale contents
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];

    // Miss bookkeeping, latched so a fill completes even if the CPU drops the request
    logic [INDEX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0]   miss_tag_q;
    logic [127:0]       fill_q;

    // Registered memory-side outputs
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-5:0] mem_address_q;
    logic [127:0]          mem_writedata_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic [1:0]         word_sel;
    logic [127:0]       line;
    logic [31:0]        hit_word;
    logic [31:0]        merged_word;
    logic               req;
    logic               hit;
    logic               served;
    logic               unused_addr;

    assign idx         = bus.cpu_address[INDEX_W+3:4];
    assign cpu_tag     = bus.cpu_address[ADDR_WIDTH-1:INDEX_W+4];
    assign word_sel    = bus.cpu_address[3:2];
    assign unused_addr = ^bus.cpu_address[1:0];

    assign line     = data_q[idx];
    assign hit_word = line[{word_sel, 5'b0} +: 32];
    assign req      = bus.cpu_read | bus.cpu_write;
    assign hit      = valid_q[idx] & (tag_q[idx] == cpu_tag);
    assign served   = (state_q == StIdle) & hit;

    assign bus.cpu_busywait  = req & ~served;
    assign bus.cpu_readdata  = (bus.cpu_read & served) ? hit_word : 32'h0;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writedata = mem_writedata_q;

    // Byte-enable merge of store data into the addressed word
    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (bus.cpu_byteen[b]) begin
                merged_word[8*b +: 8] = bus.cpu_writedata[8*b +: 8];
            end
        end
    end

    // Miss FSM with registered memory outputs; also owns the valid/dirty bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            valid_q         <= '0;
            dirty_q         <= '0;
            miss_idx_q      <= '0;
            miss_tag_q      <= '0;
            fill_q          <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && !hit) begin
                        miss_idx_q <= idx;
                        miss_tag_q <= cpu_tag;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q         <= StWriteback;
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {tag_q[idx], idx};
                            mem_writedata_q <= data_q[idx];
                        end else begin
                            state_q       <= StFetch;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {cpu_tag, idx};
                        end
                    end else if (bus.cpu_write && hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                StWriteback: begin
                    if (!bus.mem_busywait) begin
                        state_q         <= StFetch;
                        mem_write_q     <= 1'b0;
                        mem_read_q      <= 1'b1;
                        mem_address_q   <= {miss_tag_q, miss_idx_q};
                        mem_writedata_q <= '0;
                    end
                end
                StFetch: begin
                    if (!bus.mem_busywait) begin
                        state_q       <= StRefill;
                        mem_read_q    <= 1'b0;
                        mem_address_q <= '0;
                        fill_q        <= bus.mem_readdata;
                    end
                end
                StRefill: begin
                    state_q             <= StIdle;
                    valid_q[miss_idx_q] <= 1'b1;
                    dirty_q[miss_idx_q] <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag/data arrays: line install on refill, byte-merged store on a write hit
    always_ff @(posedge clk) begin
        if (state_q == StRefill) begin
            data_q[miss_idx_q] <= fill_q;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end else if (served && bus.cpu_write) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <= merged_word;
        end
    end
endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: directed CPU requests against a latency-configurable
// memory responder, a word-level cache model checked every cycle, and literal expectations.
module tb_data_cache_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_cache_controller_if bus ();

    data_cache_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [127:0] mem_store [logic [27:0]];
    logic [127:0] mem_rdata = '0;
    int lat = 4;
    int mcnt = 0;

    function automatic logic [127:0] mem_block(input logic [27:0] a);
        logic [127:0] blk;
        if (mem_store.exists(a)) return mem_store[a];
        for (int w = 0; w < 4; w++) blk[32*w +: 32] = 32'hA000_0000 | {a, 4'b0} | 32'(w);
        return blk;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_read || bus.mem_write) begin
            if (mcnt >= lat) begin
                mcnt <= 0;
                if (bus.mem_write) mem_store[bus.mem_address] = bus.mem_writedata;
            end else begin
                mcnt <= mcnt + 1;
            end
            if (bus.mem_read) mem_rdata <= mem_block(bus.mem_address);
        end else begin
            mcnt <= 0;
        end
    end

    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (mcnt < lat);
    assign bus.mem_readdata = mem_rdata;

    // ---------------- memory activity monitor ----------------
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [27:0]  mon_rd_addr = '0;
    logic [27:0]  mon_wr_addr = '0;
    logic [127:0] mon_wr_data = '0;

    always @(negedge clk) begin
        if (bus.mem_read) begin
            rd_cnt++;
            mon_rd_addr = bus.mem_address;
        end
        if (bus.mem_write) begin
            wr_cnt++;
            mon_wr_addr = bus.mem_address;
            mon_wr_data = bus.mem_writedata;
        end
    end

    // ---------------- cache model (words per line, phase of the outstanding miss) ----------------
    // phase: 0 no miss, 1 victim being written, 2 line being fetched, 3 line being installed
    logic [7:0]  m_valid;
    logic [7:0]  m_dirty;
    logic [24:0] m_tag  [8];
    logic [31:0] m_word [8][4];
    logic [127:0] m_fill;
    int m_phase = 0;

    function automatic logic m_hit(input logic [31:0] a);
        return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[31:7]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = '0;
            m_dirty = '0;
            m_phase = 0;
        end else begin
            logic [2:0] i;
            logic [1:0] w;
            i = bus.cpu_address[6:4];
            w = bus.cpu_address[3:2];
            case (m_phase)
                0: if (bus.cpu_read || bus.cpu_write) begin
                    if (m_hit(bus.cpu_address)) begin
                        if (bus.cpu_write) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.cpu_byteen[b])
                                    m_word[i][w][8*b +: 8] = bus.cpu_writedata[8*b +: 8];
                            m_dirty[i] = 1'b1;
                        end
                    end else begin
                        m_phase = (m_valid[i] && m_dirty[i]) ? 1 : 2;
                    end
                end
                1: if (!bus.mem_busywait) m_phase = 2;
                2: if (!bus.mem_busywait) begin
                    m_fill  = bus.mem_readdata;
                    m_phase = 3;
                end
                default: begin
                    for (int k = 0; k < 4; k++) m_word[i][k] = m_fill[32*k +: 32];
                    m_tag[i]   = bus.cpu_address[31:7];
                    m_valid[i] = 1'b1;
                    m_dirty[i] = 1'b0;
                    m_phase    = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [2:0]   i;
            logic         rq;
            logic         ok;
            logic [27:0]  e_addr;
            logic [127:0] e_wd;
            logic [31:0]  e_rd;
            i  = bus.cpu_address[6:4];
            rq = bus.cpu_read || bus.cpu_write;
            ok = (m_phase == 0) && m_hit(bus.cpu_address);
            e_rd = (bus.cpu_read && ok) ? m_word[i][bus.cpu_address[3:2]] : 32'h0;
            e_addr = '0;
            e_wd   = '0;
            if (m_phase == 1) begin
                e_addr = {m_tag[i], i};
                e_wd   = {m_word[i][3], m_word[i][2], m_word[i][1], m_word[i][0]};
            end else if (m_phase == 2) begin
                e_addr = {bus.cpu_address[31:7], i};
            end
            chk("cyc_busywait", 128'(bus.cpu_busywait), 128'(rq && !ok));
            chk("cyc_readdata", 128'(bus.cpu_readdata), 128'(e_rd));
            chk("cyc_mem_read", 128'(bus.mem_read), 128'(m_phase == 2));
            chk("cyc_mem_write", 128'(bus.mem_write), 128'(m_phase == 1));
            chk("cyc_mem_address", 128'(bus.mem_address), 128'(e_addr));
            chk("cyc_mem_writedata", bus.mem_writedata, e_wd);
        end
    end

    // ---------------- CPU request driver ----------------
    task automatic request(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           output logic [31:0] rdata, output int stall);
        bit done;
        @(posedge clk);
        #1;
        bus.cpu_read      = rd;
        bus.cpu_write     = wr;
        bus.cpu_address   = a;
        bus.cpu_writedata = d;
        bus.cpu_byteen    = be;
        stall = 0;
        rdata = '0;
        done  = 1'b0;
        #1;
        while (!done && stall < 200) begin
            if (!bus.cpu_busywait) begin
                done  = 1'b1;
                rdata = bus.cpu_readdata;
            end else begin
                stall++;
                @(posedge clk);
                #2;
            end
        end
        if (!done) chk("request_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdata;
        int stall;
        int rd0;
        int wr0;
        bit seen;

        bus.cpu_read      = 1'b0;
        bus.cpu_write     = 1'b0;
        bus.cpu_address   = '0;
        bus.cpu_writedata = '0;
        bus.cpu_byteen    = '0;

        // Reset
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_busywait", 128'(bus.cpu_busywait), 128'd0);
        chk("reset_mem_read", 128'(bus.mem_read), 128'd0);
        chk("reset_mem_write", 128'(bus.mem_write), 128'd0);
        chk("reset_mem_address", 128'(bus.mem_address), 128'd0);
        chk("reset_readdata", 128'(bus.cpu_readdata), 128'd0);
        cmp_en = 1'b1;

        // 1: cold read miss, memory busy 4 cycles
        lat = 4;
        rd0 = rd_cnt;
        request(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rdata, stall);
        chk("t1_readdata", 128'(rdata), 128'h A000_0040);
        chk("t1_fetch_addr", 128'(mon_rd_addr), 128'h4);
        chk("t1_fetched", 128'(rd_cnt > rd0), 128'd1);
        chk("t1_stall", 128'(stall), 128'd7);

        // 2: read hit in the same line
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        request(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, rdata, stall);
        chk("t2_readdata", 128'(rdata), 128'h A000_0041);
        chk("t2_stall", 128'(stall), 128'd0);
        chk("t2_no_mem", 128'((rd_cnt - rd0) + (wr_cnt - wr0)), 128'd0);

        // 3: partial write hit, then read back
        request(1'b0, 1'b1, 32'h48, 32'hDEAD_BEEF, 4'b0011, rdata, stall);
        chk("t3_write_stall", 128'(stall), 128'd0);
        request(1'b1, 1'b0, 32'h48, 32'h0, 4'h0, rdata, stall);
        chk("t3_readback", 128'(rdata), 128'h A000_BEEF);

        // 4: conflict miss on a dirty line
        request(1'b1, 1'b0, 32'hC0, 32'h0, 4'h0, rdata, stall);
        chk("t4_wb_addr", 128'(mon_wr_addr), 128'h4);
        chk("t4_wb_word2", 128'(mon_wr_data[95:64]), 128'h A000_BEEF);
        chk("t4_wb_word0", 128'(mon_wr_data[31:0]), 128'h A000_0040);
        chk("t4_fetch_addr", 128'(mon_rd_addr), 128'hC);
        chk("t4_readdata", 128'(rdata), 128'h A000_00C0);
        chk("t4_stall", 128'(stall), 128'd12);
        chk("t4_mem_updated", 128'(mem_block(28'h4) >> 64), 128'h A000_0043_A000_BEEF);

        // Fastest memory: busy for one cycle only
        lat = 1;
        request(1'b1, 1'b0, 32'h5C, 32'h0, 4'h0, rdata, stall);
        chk("lat1_readdata", 128'(rdata), 128'h A000_0053);
        chk("lat1_stall", 128'(stall), 128'd4);

        // 5: reset in the middle of a fetch
        lat = 4;
        @(posedge clk);
        #1;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = 32'h40;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #2;
            seen = bus.mem_read;
        end
        chk("t5_fetch_started", 128'(seen), 128'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_mem_read_drop", 128'(bus.mem_read), 128'd0);
        chk("t5_busywait_cold", 128'(bus.cpu_busywait), 128'd1);
        chk("t5_readdata", 128'(bus.cpu_readdata), 128'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.cpu_read = 1'b0;
        #1;
        chk("t5_busywait_idle", 128'(bus.cpu_busywait), 128'd0);
        rd0 = rd_cnt;
        request(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rdata, stall);
        chk("t5_refetched", 128'(rd_cnt > rd0), 128'd1);
        chk("t5_readdata_again", 128'(rdata), 128'h A000_0040);

        // 6: write miss on a clean index allocates without write-back
        wr0 = wr_cnt;
        request(1'b0, 1'b1, 32'h100, 32'h1234_5678, 4'b1001, rdata, stall);
        chk("t6_no_writeback", 128'(wr_cnt - wr0), 128'd0);
        chk("t6_fetch_addr", 128'(mon_rd_addr), 128'h10);
        request(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, rdata, stall);
        chk("t6_merged", 128'(rdata), 128'h 1200_0178);
        // Evicting the line proves it was marked dirty
        request(1'b1, 1'b0, 32'h180, 32'h0, 4'h0, rdata, stall);
        chk("t6_evict_addr", 128'(mon_wr_addr), 128'h10);
        chk("t6_evict_word0", 128'(mon_wr_data[31:0]), 128'h 1200_0178);
        chk("t6_new_line", 128'(rdata), 128'h A000_0180);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
